// File: rtl/calc1_port_driver.sv
// Drives a single calc1 request port with one operation in flight at a time:
// command/operand1, then operand2, then waits for a response or times out.
module calc1_port_driver #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        c_clk,
   input  logic        reset,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [0:3]  op_cmd,
   input  logic [0:31] op_data1,
   input  logic [0:31] op_data2,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [0:1]  res_resp,
   output logic [0:31] res_data,
   output logic        res_timeout,
   output logic [0:3]  req_cmd_out,
   output logic [0:31] req_data_out,
   input  logic [0:1]  out_resp,
   input  logic [0:31] out_data,
   output logic        busy,
   output logic        stray_resp
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_DATA,
      S_WAIT,
      S_RESP
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [0:3]  req_cmd_q, req_cmd_d;
   logic [0:31] req_data_q, req_data_d;
   logic [0:31] data2_q, data2_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [0:1]  res_resp_q, res_resp_d;
   logic [0:31] res_data_q, res_data_d;
   logic        res_timeout_q, res_timeout_d;
   logic        res_valid_q, res_valid_d;
   logic        op_ready_q, op_ready_d;
   logic        busy_q, busy_d;
   logic        stray_q, stray_d;

   always_comb begin
      state_d       = state_q;
      req_cmd_d     = 4'd0;
      req_data_d    = 32'd0;
      data2_d       = data2_q;
      cnt_d         = cnt_q;
      res_resp_d    = res_resp_q;
      res_data_d    = res_data_q;
      res_timeout_d = res_timeout_q;

      case (state_q)
         S_IDLE: begin
            if (op_valid && op_ready_q) begin
               if (op_cmd == 4'd0) begin
                  // Null command: answer locally without touching calc1.
                  state_d       = S_RESP;
                  res_resp_d    = 2'd0;
                  res_data_d    = 32'd0;
                  res_timeout_d = 1'b0;
               end else begin
                  state_d    = S_CMD;
                  req_cmd_d  = op_cmd;
                  req_data_d = op_data1;
                  data2_d    = op_data2;
               end
            end
         end
         S_CMD: begin
            state_d    = S_DATA;
            req_data_d = data2_q;
         end
         S_DATA: begin
            state_d = S_WAIT;
            cnt_d   = 8'd0;
         end
         S_WAIT: begin
            // A response on the expiry cycle still counts as a real response.
            if (out_resp != 2'd0) begin
               state_d       = S_RESP;
               res_resp_d    = out_resp;
               res_data_d    = out_data;
               res_timeout_d = 1'b0;
            end else if (cnt_q == CNT_LAST) begin
               state_d       = S_RESP;
               res_resp_d    = 2'd0;
               res_data_d    = 32'd0;
               res_timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_RESP: begin
            if (res_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Status outputs are registered copies derived from the next state.
      op_ready_d  = (state_d == S_IDLE);
      res_valid_d = (state_d == S_RESP);
      busy_d      = (state_d != S_IDLE);
      stray_d     = stray_q | ((state_q != S_WAIT) && (out_resp != 2'd0));
   end

   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         req_cmd_q     <= 4'd0;
         req_data_q    <= 32'd0;
         data2_q       <= 32'd0;
         cnt_q         <= 8'd0;
         res_resp_q    <= 2'd0;
         res_data_q    <= 32'd0;
         res_timeout_q <= 1'b0;
         res_valid_q   <= 1'b0;
         op_ready_q    <= 1'b0;
         busy_q        <= 1'b0;
         stray_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         req_cmd_q     <= req_cmd_d;
         req_data_q    <= req_data_d;
         data2_q       <= data2_d;
         cnt_q         <= cnt_d;
         res_resp_q    <= res_resp_d;
         res_data_q    <= res_data_d;
         res_timeout_q <= res_timeout_d;
         res_valid_q   <= res_valid_d;
         op_ready_q    <= op_ready_d;
         busy_q        <= busy_d;
         stray_q       <= stray_d;
      end
   end

   assign op_ready     = op_ready_q;
   assign res_valid    = res_valid_q;
   assign res_resp     = res_resp_q;
   assign res_data     = res_data_q;
   assign res_timeout  = res_timeout_q;
   assign req_cmd_out  = req_cmd_q;
   assign req_data_out = req_data_q;
   assign busy         = busy_q;
   assign stray_resp   = stray_q;

endmodule

// File: tb/tb_calc1_port_driver.sv
// Self-checking bench for calc1_port_driver: vector table, hand-written corner
// sequences and randomized operations against a latency/result model.
module tb_calc1_port_driver;

   localparam int TO = 64;

   logic        c_clk = 1'b0;
   logic        reset = 1'b0;
   logic        op_valid = 1'b0;
   logic        op_ready;
   logic [0:3]  op_cmd = 4'd0;
   logic [0:31] op_data1 = 32'd0;
   logic [0:31] op_data2 = 32'd0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [0:1]  res_resp;
   logic [0:31] res_data;
   logic        res_timeout;
   logic [0:3]  req_cmd_out;
   logic [0:31] req_data_out;
   logic [0:1]  out_resp = 2'd0;
   logic [0:31] out_data = 32'd0;
   logic        busy;
   logic        stray_resp;

   int errors = 0;
   int checks = 0;

   calc1_port_driver #(.TIMEOUT_CYCLES(TO)) dut (
      .c_clk        (c_clk),
      .reset        (reset),
      .op_valid     (op_valid),
      .op_ready     (op_ready),
      .op_cmd       (op_cmd),
      .op_data1     (op_data1),
      .op_data2     (op_data2),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_resp     (res_resp),
      .res_data     (res_data),
      .res_timeout  (res_timeout),
      .req_cmd_out  (req_cmd_out),
      .req_data_out (req_data_out),
      .out_resp     (out_resp),
      .out_data     (out_data),
      .busy         (busy),
      .stray_resp   (stray_resp)
   );

   always #5 c_clk = ~c_clk;

   typedef struct {
      string       name;
      logic [3:0]  cmd;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [1:0]  rresp;
      logic [31:0] rdata;
      int          delay;     // WAIT cycle (1-based) carrying the reply, 0 = silent
      logic [1:0]  e_resp;
      logic [31:0] e_data;
      logic        e_to;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge c_clk);
      #1;
   endtask

   // Edges from acceptance until res_valid is seen.
   function automatic int model_lat(input logic [3:0] cmd, input int delay);
      if (cmd == 4'd0) return 1;
      if (delay >= 1 && delay <= TO) return 2 + delay;
      return 2 + TO;
   endfunction

   task automatic run_op(input string nm, input logic [3:0] cmd, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [1:0] rr, input logic [31:0] rd,
                         input int delay, input logic [1:0] e_resp, input logic [31:0] e_data,
                         input logic e_to, input int hold, input bit pulse);
      int lat;
      bit done;
      chk({nm, " op_ready before"}, 32'(op_ready), 32'd1);
      op_valid = 1'b1; op_cmd = cmd; op_data1 = d1; op_data2 = d2;
      tick();
      op_valid = 1'b0; op_cmd = 4'd0;
      lat = 1;
      if (cmd != 4'd0) begin
         chk({nm, " cmd phase req_cmd"}, 32'(req_cmd_out), 32'(cmd));
         chk({nm, " cmd phase req_data"}, req_data_out, d1);
         chk({nm, " cmd phase busy"}, 32'(busy), 32'd1);
         chk({nm, " cmd phase res_valid"}, 32'(res_valid), 32'd0);
         tick();
         chk({nm, " data phase req_cmd"}, 32'(req_cmd_out), 32'd0);
         chk({nm, " data phase req_data"}, req_data_out, d2);
         tick();
         chk({nm, " wait req_data"}, req_data_out, 32'd0);
         done = 1'b0;
         for (int w = 1; w <= 300 && !done; w++) begin
            if (w == delay) begin
               out_resp = rr; out_data = rd;
            end
            tick();
            out_resp = 2'd0; out_data = 32'd0;
            lat = 2 + w;
            if (res_valid) done = 1'b1;
         end
         chk({nm, " latency"}, 32'(lat), 32'(model_lat(cmd, delay)));
      end
      chk({nm, " res_valid"}, 32'(res_valid), 32'd1);
      chk({nm, " res_resp"}, 32'(res_resp), 32'(e_resp));
      chk({nm, " res_data"}, res_data, e_data);
      chk({nm, " res_timeout"}, 32'(res_timeout), 32'(e_to));
      chk({nm, " resp req_cmd"}, 32'(req_cmd_out), 32'd0);
      chk({nm, " resp op_ready"}, 32'(op_ready), 32'd0);
      for (int h = 0; h < hold; h++) begin
         if (pulse) begin
            op_valid = 1'b1; op_cmd = 4'd3; op_data1 = 32'hCAFE_0001;
         end
         tick();
         chk({nm, " hold res_valid"}, 32'(res_valid), 32'd1);
         chk({nm, " hold res_resp"}, 32'(res_resp), 32'(e_resp));
         chk({nm, " hold res_data"}, res_data, e_data);
         chk({nm, " hold res_timeout"}, 32'(res_timeout), 32'(e_to));
         chk({nm, " hold op_ready"}, 32'(op_ready), 32'd0);
         chk({nm, " hold req_cmd"}, 32'(req_cmd_out), 32'd0);
      end
      op_valid = 1'b0; op_cmd = 4'd0;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk({nm, " done res_valid"}, 32'(res_valid), 32'd0);
      chk({nm, " done op_ready"}, 32'(op_ready), 32'd1);
      chk({nm, " done busy"}, 32'(busy), 32'd0);
      chk({nm, " stray_resp"}, 32'(stray_resp), 32'd0);
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, " req_cmd"}, 32'(req_cmd_out), 32'd0);
      chk({nm, " req_data"}, req_data_out, 32'd0);
      chk({nm, " res_valid"}, 32'(res_valid), 32'd0);
      chk({nm, " res_resp"}, 32'(res_resp), 32'd0);
      chk({nm, " res_data"}, res_data, 32'd0);
      chk({nm, " res_timeout"}, 32'(res_timeout), 32'd0);
      chk({nm, " busy"}, 32'(busy), 32'd0);
      chk({nm, " stray_resp"}, 32'(stray_resp), 32'd0);
      chk({nm, " op_ready"}, 32'(op_ready), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[7];
      vecs[0] = '{"add",   4'd1,  32'h0000_0001, 32'h1FFF_FFFF, 2'd1, 32'h2000_0000, 3,  2'd1, 32'h2000_0000, 1'b0};
      vecs[1] = '{"ovf",   4'd1,  32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0000_0000, 3,  2'd2, 32'h0000_0000, 1'b0};
      vecs[2] = '{"tmo",   4'd5,  32'h1234_5678, 32'h9ABC_DEF0, 2'd0, 32'h0000_0000, 0,  2'd0, 32'h0000_0000, 1'b1};
      vecs[3] = '{"null",  4'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 32'h0000_0000, 0,  2'd0, 32'h0000_0000, 1'b0};
      vecs[4] = '{"race",  4'd2,  32'h0000_0010, 32'h0000_0003, 2'd3, 32'hDEAD_BEEF, 64, 2'd3, 32'hDEAD_BEEF, 1'b0};
      vecs[5] = '{"late",  4'd2,  32'h0000_0010, 32'h0000_0003, 2'd1, 32'h0000_1234, 65, 2'd0, 32'h0000_0000, 1'b1};
      vecs[6] = '{"badcmd",4'd15, 32'h0000_00FF, 32'h0000_0001, 2'd2, 32'h0000_00A5, 1,  2'd2, 32'h0000_00A5, 1'b0};

      // Reset asserted from time zero: everything low before any clock edge.
      #3;
      chk_all_zero("por");
      tick(); tick();
      reset = 1'b1;
      chk("por op_ready before edge", 32'(op_ready), 32'd0);
      tick();
      chk("por op_ready after edge", 32'(op_ready), 32'd1);
      chk("por busy", 32'(busy), 32'd0);

      for (int i = 0; i < 7; i++) begin
         run_op(vecs[i].name, vecs[i].cmd, vecs[i].d1, vecs[i].d2, vecs[i].rresp,
                vecs[i].rdata, vecs[i].delay, vecs[i].e_resp, vecs[i].e_data, vecs[i].e_to, 0, 1'b0);
      end

      // Backpressure with op_valid pulsed while a result is pending.
      run_op("bp", 4'd3, 32'h0000_0007, 32'h0000_0009, 2'd1, 32'h0000_0055, 2,
             2'd1, 32'h0000_0055, 1'b0, 5, 1'b1);
      tick();
      chk("bp no new op busy", 32'(busy), 32'd0);
      chk("bp no new op req_cmd", 32'(req_cmd_out), 32'd0);

      // Reset in the middle of WAIT, then a late calc1 reply lands in IDLE.
      op_valid = 1'b1; op_cmd = 4'd2; op_data1 = 32'h1; op_data2 = 32'h2;
      tick();
      op_valid = 1'b0; op_cmd = 4'd0;
      tick(); tick(); tick();
      chk("rst pre busy", 32'(busy), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk_all_zero("rst async");
      tick(); tick();
      reset = 1'b1;
      tick();
      chk("rst op_ready", 32'(op_ready), 32'd1);
      out_resp = 2'd1; out_data = 32'h0000_4444;
      tick();
      out_resp = 2'd0; out_data = 32'd0;
      chk("rst stray_resp set", 32'(stray_resp), 32'd1);
      chk("rst no res_valid", 32'(res_valid), 32'd0);
      chk("rst idle busy", 32'(busy), 32'd0);
      tick();
      chk("rst stray sticky", 32'(stray_resp), 32'd1);
      chk("rst still no res_valid", 32'(res_valid), 32'd0);
      #2;
      reset = 1'b0;
      #1;
      chk("rst2 stray cleared", 32'(stray_resp), 32'd0);
      tick();
      reset = 1'b1;
      tick();

      // Randomized operations against the latency/result model.
      for (int i = 0; i < 20; i++) begin
         logic [3:0]  cmd;
         logic [31:0] d1, d2, rd;
         logic [1:0]  rr, e_resp;
         logic [31:0] e_data;
         logic        e_to;
         int          delay;
         cmd   = 4'($urandom_range(0, 15));
         d1    = $urandom;
         d2    = $urandom;
         rd    = $urandom;
         rr    = 2'($urandom_range(1, 3));
         delay = $urandom_range(0, 70);
         if (cmd == 4'd0) begin
            e_resp = 2'd0; e_data = 32'd0; e_to = 1'b0;
         end else if (delay >= 1 && delay <= TO) begin
            e_resp = rr; e_data = rd; e_to = 1'b0;
         end else begin
            e_resp = 2'd0; e_data = 32'd0; e_to = 1'b1;
         end
         run_op($sformatf("rnd%0d", i), cmd, d1, d2, rr, rd, delay, e_resp, e_data, e_to,
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/calc1_port_driver.md
CALC1_PORT_DRIVER -- requirements
Module: calc1_port_driver

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, is the number of WAIT-state cycles before a response is declared lost; legal range 1..255.
REQ-002 c_clk  in  1  single block clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 op_valid  in  1  operation request from client.
REQ-005 op_ready  out  1  driver can accept an operation.
REQ-006 op_cmd  in  [0:3]  calc1 command code.
REQ-007 op_data1  in  [0:31]  first operand.
REQ-008 op_data2  in  [0:31]  second operand.
REQ-009 res_valid  out  1  result available to client.
REQ-010 res_ready  in  1  client accepts result.
REQ-011 res_resp  out  [0:1]  captured calc1 response code.
REQ-012 res_data  out  [0:31]  captured calc1 result data.
REQ-013 res_timeout  out  1  result produced by timeout, not by calc1.
REQ-014 req_cmd_out  out  [0:3]  to calc1 reqN_cmd_in.
REQ-015 req_data_out  out  [0:31]  to calc1 reqN_data_in.
REQ-016 out_resp  in  [0:1]  from calc1 out_respN.
REQ-017 out_data  in  [0:31]  from calc1 out_dataN.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 stray_resp  out  1  sticky flag: non-zero out_resp seen outside WAIT.

Function
REQ-020 Block SHALL drive one calc1 port with at most one outstanding operation.
REQ-021 FSM states SHALL be IDLE, CMD, DATA, WAIT, RESP; all outputs registered.
REQ-022 IDLE: op_ready=1; op_valid&&op_ready at edge k SHALL capture op_cmd/op_data1/op_data2 and go to CMD, or to RESP if op_cmd==0.
REQ-023 CMD (cycle k+1): req_cmd_out=captured cmd, req_data_out=op_data1; next state DATA.
REQ-024 DATA (cycle k+2): req_cmd_out=0, req_data_out=op_data2; next state WAIT, timeout counter cleared.
REQ-025 WAIT: req_cmd_out=0, req_data_out=0; out_resp sampled every edge from the first WAIT cycle.
REQ-026 WAIT, out_resp!=0: capture out_resp and out_data into res_resp/res_data, res_timeout=0, go to RESP.
REQ-027 WAIT, out_resp==0: increment 8-bit counter; when counter reaches TIMEOUT_CYCLES-1, go to RESP with res_resp=0, res_data=0, res_timeout=1.
REQ-028 A response and counter expiry in the same cycle SHALL resolve as response (REQ-026 wins).
REQ-029 op_cmd==0 SHALL not drive calc1; result is res_resp=0, res_data=0, res_timeout=0, one cycle after acceptance.
REQ-030 RESP: res_valid=1; res_resp/res_data/res_timeout held stable until res_valid&&res_ready, then IDLE; op_ready=0.
REQ-031 res_valid SHALL be 0 in every state other than RESP.
REQ-032 op_ready SHALL be 0 in all states except IDLE; op_valid outside IDLE SHALL be ignored.
REQ-033 Non-zero out_resp in any state other than WAIT SHALL set stray_resp; it clears only on reset.
REQ-034 Command codes SHALL be passed through unchecked; invalid codes are reported by calc1 response.

Reset
REQ-035 reset low SHALL immediately force state IDLE, req_cmd_out=0, req_data_out=0, res_valid=0, res_resp=0, res_data=0, res_timeout=0, busy=0, stray_resp=0, counter=0, independent of c_clk.
REQ-036 op_ready SHALL be 0 while reset is low and 1 from the first edge after release.
REQ-037 Reset during any state SHALL abandon the operation with no result produced.

Verification
REQ-038 Add: op_cmd=1, data1=0x0000_0001, data2=0x1FFF_FFFF; model replies resp=1, data=0x2000_0000 3 cycles after DATA -> req_cmd_out 1 then 0, res_resp=1, res_data=0x2000_0000, res_timeout=0.
REQ-039 Overflow: op_cmd=1, 0xFFFF_FFFF + 0x0000_0001; model replies resp=2, data=0 -> res_resp=2, res_data=0.
REQ-040 Timeout: op_cmd=5, model silent -> res_valid exactly 64 WAIT cycles after DATA, res_timeout=1, res_resp=0, res_data=0.
REQ-041 Backpressure: result pending, res_ready low 5 cycles, op_valid pulsed -> outputs stable, op_ready=0, no new op accepted; res_ready high -> IDLE next cycle.
REQ-042 Reset mid-WAIT: reset low 2 cycles -> all outputs 0 immediately; model response arriving in IDLE after release -> stray_resp=1, no res_valid.
REQ-043 Null op: op_cmd=0 -> req_cmd_out stays 0, res_valid one cycle after acceptance with res_resp=0.
